// File: rtl/decade_pkg.sv
// Shared types and constants for the two-digit BCD down counter.
package decade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Any out-of-range digit is pulled back to the largest legal BCD value.
    function automatic bcd_t clamp_bcd(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down, wrapping 0 -> 9 with a borrow to the next digit.
module bcd_digit_down
    import decade_pkg::*;
(
    input  logic cp,
    input  logic reset,
    input  logic load,
    input  bcd_t value,
    input  logic dec,
    output bcd_t digit,
    output logic borrow
);

    assign borrow = dec && (digit == 4'd0);

    // Load wins over a decrement so the parent can override a terminal tick.
    always_ff @(posedge cp) begin
        if (reset) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= value;
        end else if (dec) begin
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/decade_down_counter.sv
// Two-digit BCD down counter with IDLE/RUN/DONE control and a one-cycle terminal pulse.
// Define DECADE_DOWN_AUTO_RELOAD_EN to reload and keep running at terminal count.
module decade_down_counter
    import decade_pkg::*;
(
    input  logic       cp,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] din_tens,
    input  logic [3:0] din_ones,
    input  logic       start,
    input  logic       x,
    output logic       q,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done
);

    state_t state;
    state_t state_next;
    bcd_t   reload_tens;
    bcd_t   reload_ones;
    logic   q_next;
    logic   dig_load;
    bcd_t   val_tens;
    bcd_t   val_ones;
    logic   dec;
    logic   ones_borrow;
    logic   tens_borrow;

    assign dec = (state == RUN) && x && !load;

    // Tens borrowing means the count was already 00 when the tick arrived.
    always_comb begin
        state_next = state;
        q_next     = 1'b0;
        dig_load   = 1'b0;
        val_tens   = reload_tens;
        val_ones   = reload_ones;
        if (load) begin
            dig_load   = 1'b1;
            val_tens   = clamp_bcd(din_tens);
            val_ones   = clamp_bcd(din_ones);
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (tens_borrow) begin
                        q_next   = 1'b1;
                        dig_load = 1'b1;
`ifdef DECADE_DOWN_AUTO_RELOAD_EN
                        state_next = RUN;
`else
                        val_tens   = 4'd0;
                        val_ones   = 4'd0;
                        state_next = DONE;
`endif
                    end
                end
                DONE: begin
                    if (start) begin
                        dig_load   = 1'b1;
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge cp) begin
        if (reset) begin
            state       <= IDLE;
            reload_tens <= 4'd0;
            reload_ones <= 4'd0;
            q           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (load) begin
                reload_tens <= clamp_bcd(din_tens);
                reload_ones <= clamp_bcd(din_ones);
            end
        end
    end

    bcd_digit_down u_ones (
        .cp     (cp),
        .reset  (reset),
        .load   (dig_load),
        .value  (val_ones),
        .dec    (dec),
        .digit  (ones),
        .borrow (ones_borrow)
    );

    bcd_digit_down u_tens (
        .cp     (cp),
        .reset  (reset),
        .load   (dig_load),
        .value  (val_tens),
        .dec    (ones_borrow),
        .digit  (tens),
        .borrow (tens_borrow)
    );

endmodule

// File: tb/tb_decade_down_counter.sv
// Directed self-checking bench for decade_down_counter; observed vector is {tens,ones,q,busy,done}.
module tb_decade_down_counter;

    logic        cp = 1'b0;
    logic        reset;
    logic        load;
    logic [3:0]  din_tens;
    logic [3:0]  din_ones;
    logic        start;
    logic        x;
    logic        q;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        busy;
    logic        done;
    logic [10:0] obs;
    logic [10:0] want;
    int          checks = 0;
    int          errors = 0;

    decade_down_counter dut (
        .cp       (cp),
        .reset    (reset),
        .load     (load),
        .din_tens (din_tens),
        .din_ones (din_ones),
        .start    (start),
        .x        (x),
        .q        (q),
        .tens     (tens),
        .ones     (ones),
        .busy     (busy),
        .done     (done)
    );

    always #5 cp = ~cp;

    assign obs = {tens, ones, q, busy, done};

    // Expected vector from a decimal count value, independent of the digit logic.
    function automatic logic [10:0] expv(input int v, input logic eq, input logic eb, input logic ed);
        return {4'(v / 10), 4'(v % 10), eq, eb, ed};
    endfunction

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; din_tens = 4'd5; din_ones = 4'd5; start = 1'b1; x = 1'b1;
        step(); step();
        want = expv(0, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL reset_priority: got %b want %b", obs, want);
        end
        reset = 1'b0; load = 1'b0; start = 1'b0; x = 1'b0;
        step();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b want %b", obs, want);
        end
    endtask

    task automatic test_countdown();
        load = 1'b1; din_tens = 4'd1; din_ones = 4'd2;
        step();
        load = 1'b0;
        want = expv(12, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL load12: got %b want %b", obs, want);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        want = expv(12, 0, 1, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL start12: got %b want %b", obs, want);
        end
        x = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            want = expv(12 - k, 0, 1, 0);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL countdown tick %0d: got %b want %b", k, obs, want);
            end
        end
        step();
`ifdef DECADE_DOWN_AUTO_RELOAD_EN
        want = expv(12, 1, 1, 0);
`else
        want = expv(0, 1, 0, 1);
`endif
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL terminal_tick13: got %b want %b", obs, want);
        end
        x = 1'b0;
        step();
`ifdef DECADE_DOWN_AUTO_RELOAD_EN
        want = expv(12, 0, 1, 0);
`else
        want = expv(0, 0, 0, 1);
`endif
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL after_terminal: got %b want %b", obs, want);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        want = expv(12, 0, 1, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL done_restart: got %b want %b", obs, want);
        end
        step();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL hold_x0: got %b want %b", obs, want);
        end
    endtask

    task automatic test_start_ignored();
        x = 1'b1;
        step();
        x = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        want = expv(11, 0, 1, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL start_in_run: got %b want %b", obs, want);
        end
    endtask

    task automatic test_zero_load();
        load = 1'b1; din_tens = 4'd0; din_ones = 4'd0;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0; x = 1'b1;
        step();
        x = 1'b0;
`ifdef DECADE_DOWN_AUTO_RELOAD_EN
        want = expv(0, 1, 1, 0);
`else
        want = expv(0, 1, 0, 1);
`endif
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL zero_first_tick: got %b want %b", obs, want);
        end
    endtask

    task automatic test_clamp_and_override();
        load = 1'b1; din_tens = 4'hF; din_ones = 4'hB;
        step();
        want = expv(99, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL clamp_FB: got %b want %b", obs, want);
        end
        din_tens = 4'hC; din_ones = 4'd3;
        step();
        want = expv(93, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL clamp_C3: got %b want %b", obs, want);
        end
        din_tens = 4'd0; din_ones = 4'd7;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0; x = 1'b1;
        step(); step();
        want = expv(5, 0, 1, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL run_at_05: got %b want %b", obs, want);
        end
        load = 1'b1; start = 1'b1; din_tens = 4'd3; din_ones = 4'd1;
        step();
        load = 1'b0; start = 1'b0; x = 1'b0;
        want = expv(31, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL load_in_run: got %b want %b", obs, want);
        end
    endtask

    task automatic test_x_gating_and_abort();
        int seq_x [4] = '{1, 0, 1, 0};
        int seq_v [4] = '{2, 2, 1, 1};
        load = 1'b1; din_tens = 4'd0; din_ones = 4'd3;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = seq_x[i][0];
            step();
            want = expv(seq_v[i], 0, 1, 0);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL x_gating step %0d: got %b want %b", i, obs, want);
            end
        end
        reset = 1'b1; x = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            want = expv(0, 0, 0, 0);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL abort_no_q cycle %0d: got %b want %b", i, obs, want);
            end
            step();
        end
        x = 1'b0;
    endtask

`ifdef DECADE_DOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        int rem;
        load = 1'b1; din_tens = 4'd0; din_ones = 4'd2;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0; x = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            rem  = k % 3;
            want = expv((rem == 0) ? 2 : 2 - rem, (rem == 0), 1, 0);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL auto_reload tick %0d: got %b want %b", k, obs, want);
            end
        end
        x = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; load = 1'b0; start = 1'b0; x = 1'b0;
        din_tens = 4'd0; din_ones = 4'd0;
        test_reset();
        test_countdown();
        test_start_ignored();
        test_zero_load();
        test_clamp_and_override();
        test_x_gating_and_abort();
`ifdef DECADE_DOWN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
